// File: rtl/line_sequencer.sv
// line_sequencer: frame-level raster controller that drives the line timer and emits line/frame timing.
// Optional watchdog on stalled line_end is compiled in with LINE_SEQ_WATCHDOG_EN.
module line_sequencer #(
  parameter int LINE_W       = 10,
  parameter int TOTAL_LINES  = 525,
  parameter int ACTIVE_LINES = 480,
  parameter int VSYNC_START  = 490,
  parameter int VSYNC_LINES  = 2,
  parameter int WDOG_CYCLES  = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              line_end,
  output logic              en_line_timer,
  output logic              busy,
  output logic [LINE_W-1:0] line_cnt,
  output logic              line_start,
  output logic              active_line,
  output logic              vsync,
  output logic              frame_start,
  output logic              frame_done,
  output logic              timeout_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  // line-domain constants carry one extra bit so ACTIVE_LINES may equal 2^LINE_W
  localparam logic [LINE_W:0] LAST = (LINE_W+1)'(TOTAL_LINES - 1);
  localparam logic [LINE_W:0] ACT  = (LINE_W+1)'(ACTIVE_LINES);
  localparam logic [LINE_W:0] VS0  = (LINE_W+1)'(VSYNC_START);
  localparam logic [LINE_W:0] VS1  = (LINE_W+1)'(VSYNC_START + VSYNC_LINES);
  logic [0:0]      state;
  logic            stop_pend;
  logic            counted;
  logic            last_line;
  logic            wdog_hit;
  logic [LINE_W:0] next_line;
  function automatic logic is_active(input logic [LINE_W:0] l);
    return l < ACT;
  endfunction
  function automatic logic is_vsync(input logic [LINE_W:0] l);
    return l >= VS0 && l < VS1;
  endfunction
  assign counted   = state == RUN && line_end && en_line_timer;
  assign last_line = {1'b0, line_cnt} == LAST;
  assign next_line = last_line ? '0 : {1'b0, line_cnt} + 1'b1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      stop_pend     <= 1'b0;
      en_line_timer <= 1'b0;
      busy          <= 1'b0;
      line_cnt      <= '0;
      line_start    <= 1'b0;
      active_line   <= 1'b0;
      vsync         <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state         <= RUN;
          stop_pend     <= 1'b0;
          en_line_timer <= 1'b1;
          busy          <= 1'b1;
          line_cnt      <= '0;
          line_start    <= 1'b1;
          frame_start   <= 1'b1;
          active_line   <= is_active('0);
          vsync         <= is_vsync('0);
        end
      end else begin
        if (stop)
          stop_pend <= 1'b1;
        // halt at frame end (stop arriving on the final edge still counts) or on watchdog expiry
        if (wdog_hit || (counted && last_line && (stop_pend || stop))) begin
          state         <= IDLE;
          stop_pend     <= 1'b0;
          en_line_timer <= 1'b0;
          busy          <= 1'b0;
          line_cnt      <= '0;
          active_line   <= 1'b0;
          vsync         <= 1'b0;
          frame_done    <= !wdog_hit;
        end else if (counted) begin
          line_cnt    <= next_line[LINE_W-1:0];
          line_start  <= 1'b1;
          frame_start <= last_line;
          frame_done  <= last_line;
          active_line <= is_active(next_line);
          vsync       <= is_vsync(next_line);
        end
      end
    end
  end
`ifdef LINE_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
  assign wdog_hit = state == RUN && !counted && wdog_cnt == WDOG_W'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wdog_cnt    <= (state == IDLE || counted) ? '0 : wdog_cnt + 1'b1;
      timeout_err <= (state == IDLE && start) ? 1'b0 : (timeout_err || wdog_hit);
    end
  end
`else
  // never true for a legal WDOG_CYCLES; keeps the parameter referenced
  assign wdog_hit    = WDOG_CYCLES < 0;
  assign timeout_err = 1'b0;
`endif
endmodule
